// File: rtl/prog_seq_counter_pkg.sv
// Shared constants and helpers for the programmable sequence counter.
//   DEF_WIDTH   : default code width of Q and of the table entries
//   DEF_SEQ_LEN : default table depth
//   DEF_IDXW    : default index width
//   reset_code(): code loaded into table entry i on reset (identity map)
package prog_seq_counter_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_SEQ_LEN = 8;
  localparam int DEF_IDXW    = 3;

  // The caller truncates the result to its own code width.
  function automatic int unsigned reset_code(input int unsigned i);
    return i;
  endfunction

endpackage

// File: rtl/seq_table.sv
// Code table for the sequence counter: register file, write port,
// read mux and lowest-index match search.
//   Clk, nReset        : clock, synchronous active-low reset (identity table)
//   wr_en/addr/data    : table write port; addresses >= SEQ_LEN are dropped
//   rd_idx -> rd_data  : combinational read of the current entry
//   key, len           : search value and active length (entries 0..len-1)
//   found, match_idx   : search result; lowest matching index wins
module seq_table
  import prog_seq_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  parameter int IDXW    = DEF_IDXW
) (
  input  logic            Clk,
  input  logic            nReset,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDXW-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  input  logic [WIDTH-1:0] key,
  input  logic [IDXW:0]   len,
  output logic            found,
  output logic [IDXW-1:0] match_idx
);

  localparam logic [IDXW:0] SEQ_LEN_V = (IDXW+1)'(SEQ_LEN);

  logic [WIDTH-1:0] tbl [SEQ_LEN];

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        tbl[i] <= WIDTH'(reset_code(i));
      end
    end else if (wr_en && ({1'b0, wr_addr} < SEQ_LEN_V)) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_idx} < SEQ_LEN_V) begin
      rd_data = tbl[rd_idx];
    end
  end

  // Scan from the top down so the lowest matching index is the last one kept.
  always_comb begin
    found     = 1'b0;
    match_idx = '0;
    for (int i = SEQ_LEN - 1; i >= 0; i--) begin
      if ((i < int'(len)) && (tbl[i] == key)) begin
        found     = 1'b1;
        match_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/prog_seq_counter.sv
// Programmable sequence counter: steps an index through a writable code
// table and presents table[idx] as the current code.
//   Clk, nReset          : clock, synchronous active-low reset
//   load, data_in        : jump to the lowest index holding data_in
//   count_en, up, wrap   : step direction and end behaviour (wrap / saturate)
//   len_cfg              : active length; 0 or > SEQ_LEN selects SEQ_LEN
//   wr_en/addr/data      : table write port
//   Q, idx               : current code and index
//   tc                   : terminal count in the selected direction
//   load_err             : one-cycle pulse after a load whose value was absent
module prog_seq_counter
  import prog_seq_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  parameter int IDXW    = DEF_IDXW
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             load,
  input  logic             count_en,
  input  logic             up,
  input  logic             wrap,
  input  logic [IDXW:0]    len_cfg,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] Q,
  output logic [IDXW-1:0]  idx,
  output logic             tc,
  output logic             load_err
);

  localparam logic [IDXW:0] SEQ_LEN_V = (IDXW+1)'(SEQ_LEN);
  localparam logic [IDXW:0] ONE_V     = (IDXW+1)'(1);

  logic [IDXW:0]   len_act;
  logic [IDXW-1:0] last_idx;
  logic            idx_over;
  logic            found;
  logic [IDXW-1:0] match_idx;
  logic [IDXW-1:0] idx_nxt;
  logic            err_nxt;

  assign len_act  = ((len_cfg == '0) || (len_cfg > SEQ_LEN_V)) ? SEQ_LEN_V : len_cfg;
  assign last_idx = IDXW'(len_act - ONE_V);
  // Index left beyond the end after the active length was shrunk.
  assign idx_over = ({1'b0, idx} >= len_act);

  seq_table #(
    .WIDTH   (WIDTH),
    .SEQ_LEN (SEQ_LEN),
    .IDXW    (IDXW)
  ) u_table (
    .Clk       (Clk),
    .nReset    (nReset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_idx    (idx),
    .rd_data   (Q),
    .key       (data_in),
    .len       (len_act),
    .found     (found),
    .match_idx (match_idx)
  );

  assign tc = up ? (idx == last_idx) : (idx == '0);

  always_comb begin
    idx_nxt = idx;
    err_nxt = 1'b0;
    if (load) begin
      if (found) idx_nxt = match_idx;
      else       err_nxt = 1'b1;
    end else if (count_en) begin
      if (idx_over) begin
        idx_nxt = up ? '0 : last_idx;
      end else if (up) begin
        if (idx == last_idx) idx_nxt = wrap ? '0 : last_idx;
        else                 idx_nxt = idx + 1'b1;
      end else begin
        if (idx == '0) idx_nxt = wrap ? last_idx : '0;
        else           idx_nxt = idx - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      idx      <= '0;
      load_err <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_prog_seq_counter.sv
module tb_prog_seq_counter;

  logic       Clk = 1'b0;
  logic       nReset, load, count_en, up, wrap, wr_en;
  logic [3:0] len_cfg, data_in, wr_data;
  logic [2:0] wr_addr;
  logic [3:0] Q;
  logic [2:0] idx;
  logic       tc, load_err;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  prog_seq_counter dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .load     (load),
    .count_en (count_en),
    .up       (up),
    .wrap     (wrap),
    .len_cfg  (len_cfg),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .Q        (Q),
    .idx      (idx),
    .tc       (tc),
    .load_err (load_err)
  );

  typedef struct {
    logic       nr, ld, ce, up, wp;
    logic [3:0] len, din;
    logic       we;
    logic [2:0] wa;
    logic [3:0] wd;
    logic [3:0] eq;
    logic [2:0] eidx;
    logic       etc, eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic nr, ld, ce, u, wp, input int len, din,
                              input logic we, input int wa, wd, eq, eidx,
                              input logic etc, eerr);
    vec_t v;
    v.nr = nr; v.ld = ld; v.ce = ce; v.up = u; v.wp = wp;
    v.len = 4'(len); v.din = 4'(din); v.we = we; v.wa = 3'(wa); v.wd = 4'(wd);
    v.eq = 4'(eq); v.eidx = 3'(eidx); v.etc = etc; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    @(negedge Clk);
    nReset = v.nr; load = v.ld; count_en = v.ce; up = v.up; wrap = v.wp;
    len_cfg = v.len; data_in = v.din; wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    @(posedge Clk);
    #1;
    chk($sformatf("v%0d.Q", n), int'(Q), int'(v.eq));
    chk($sformatf("v%0d.idx", n), int'(idx), int'(v.eidx));
    chk($sformatf("v%0d.tc", n), int'(tc), int'(v.etc));
    chk($sformatf("v%0d.load_err", n), int'(load_err), int'(v.eerr));
  endtask

  initial begin
    nReset = 1'b0; load = 1'b0; count_en = 1'b0; up = 1'b1; wrap = 1'b1;
    len_cfg = '0; data_in = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    //             nr ld ce up wp len din we wa wd | Q idx tc err
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 2,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 2, 3,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 3, 6,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 4, 8,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 5, 9,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 6, 15,  0, 0, 0, 0));
    // wrap up through the 7-entry sequence
    vecs.push_back(mk(1, 1, 0, 1, 1, 7, 6, 0, 0, 0,   6, 3, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 7, 0, 0, 0, 0,   8, 4, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 7, 0, 0, 0, 0,   9, 5, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 7, 0, 0, 0, 0,  15, 6, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 7, 0, 0, 0, 0,   0, 0, 0, 0));
    // wrap down
    vecs.push_back(mk(1, 1, 0, 0, 1, 7, 6, 0, 0, 0,   6, 3, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 7, 0, 0, 0, 0,   3, 2, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 7, 0, 0, 0, 0,   2, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 7, 0, 0, 0, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 7, 0, 0, 0, 0,  15, 6, 0, 0));
    // saturation at both ends
    vecs.push_back(mk(1, 0, 1, 1, 0, 7, 0, 0, 0, 0,  15, 6, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 7, 0, 0, 0, 0,  15, 6, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 7, 0, 0, 0, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 7, 0, 0, 0, 0,   0, 0, 1, 0));
    // load miss pulse, load priority over count
    vecs.push_back(mk(1, 1, 0, 1, 0, 7, 5, 0, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 7, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 7, 9, 0, 0, 0,   9, 5, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 7, 5, 0, 0, 0,   9, 5, 0, 1));
    // shrinking the active length with idx beyond the new end
    vecs.push_back(mk(1, 0, 1, 1, 1, 7, 0, 0, 0, 0,  15, 6, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 4, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 7, 15, 0, 0, 0, 15, 6, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 4, 0, 0, 0, 0,  15, 6, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 4, 0, 0, 0, 0,   6, 3, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 4, 15, 0, 0, 0,  6, 3, 0, 1));
    // reset overrides everything, identity table comes back
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 3, 1, 5, 14,  0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 5, 0, 0, 0,   5, 5, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 6, 0, 0, 0,   6, 6, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 12, 0, 0, 0, 0,  7, 7, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0));
    // same-edge write and load: search sees old contents, Q shows new
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 2, 1, 2, 12, 12, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 2, 13, 13, 2, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Reset then walk the identity table by value search.
    @(negedge Clk);
    nReset = 1'b0; load = 1'b0; count_en = 1'b1; wr_en = 1'b0; len_cfg = '0; up = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst2.idx", int'(idx), 0);
    for (int i = 7; i >= 0; i--) begin
      @(negedge Clk);
      nReset = 1'b1; load = 1'b1; count_en = 1'b0; data_in = 4'(i);
      @(posedge Clk);
      #1;
      chk($sformatf("ident%0d.idx", i), int'(idx), i);
      chk($sformatf("ident%0d.Q", i), int'(Q), i);
    end

    // Saturating up-count from 0 over the full default length.
    @(negedge Clk);
    load = 1'b0; count_en = 1'b1; wrap = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("sat%0d.idx", i), int'(idx), (i > 7) ? 7 : i);
      chk($sformatf("sat%0d.tc", i), int'(tc), (i >= 7) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
